counter_tick_sequencer: RTL and testbench
=========================================

Name: counter_tick_sequencer

Overview:
- Single-clock controller that sequences the 4-bit LED counter module through its EN_count_value/RDY_count_value method handshake.
- Replaces ripple-clocking the counter from a prescaler bit: the counter runs on CLK and this block issues one-cycle enable pulses at a programmable rate.
- Supports run, stop and single-step control.
- Latches the counter value for the LED outputs and flags ticks lost while the counter is not ready.

Parameters:
- PRESCALE_W, 21, width of prescaler and cfg_div.
- COUNT_W, 4, width of counter value and display.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- cfg_div  input  PRESCALE_W  prescaler terminal count; tick period = cfg_div+1 cycles.
- start  input  1  pulse: enter RUN.
- stop  input  1  pulse: enter IDLE.
- step  input  1  pulse: one count when IDLE.
- count_value  input  COUNT_W  current counter value from counter module.
- RDY_count_value  input  1  counter ready to accept an enable.
- EN_count_value  output  1  one-cycle enable to counter.
- display  output  COUNT_W  latched counter value for LEDs.
- running  output  1  high in RUN.
- missed  output  1  sticky: a tick was dropped.
- clr_missed  input  1  clears missed.

Behaviour:
- Reset values (RST high at a CLK edge): state=IDLE, prescaler=0, tick_pend=0, EN_count_value=0, display=0, running=0, missed=0. RST overrides all other inputs in the same cycle.
- States:
  - IDLE: prescaler held at 0, tick_pend cleared.
  - RUN: prescaler counts.
  - STEP: waits for RDY, issues one EN, then returns to IDLE.
- Control priority per cycle: stop > start > step.
  - stop in any state -> IDLE next cycle; an EN already registered this cycle still completes.
  - start in IDLE or STEP -> RUN; prescaler restarts from 0.
  - start in RUN is ignored.
  - step is honoured only in IDLE (-> STEP) and is ignored in RUN/STEP.
- Prescaler in RUN:
  - Increments each cycle.
  - When prescaler >= cfg_div: wraps to 0 and raises tick.
  - The >= compare means lowering cfg_div mid-run wraps on the next cycle.
  - cfg_div=0 gives a tick every cycle.
- tick_pend:
  - Set by tick; cleared when EN is issued.
  - A tick while tick_pend=1 sets missed=1; only one pending tick is ever held.
- EN_count_value:
  - Registered output.
  - Asserted in the cycle after the condition (RUN, tick_pend=1, RDY_count_value=1, no stop) is seen.
  - Never high two consecutive cycles; tick_pend is cleared when EN registers.
- STEP:
  - EN asserted the first cycle after RDY_count_value=1 is seen in STEP.
  - State returns to IDLE the same cycle EN is high.
- display:
  - Loads count_value two cycles after EN is high. The counter updates on the EN edge; display samples on the following edge.
  - Held otherwise, including through stop.
- missed:
  - clr_missed clears it.
  - Simultaneous set and clear -> missed=1 (set wins).
- running = (state==RUN), registered.
- Counter value width and wrap belong to the counter (15 -> 0); this block does no arithmetic on count_value.

Test Plan:
1. Reset and hold: RST=1 for 3 cycles with start=1 -> EN=0, display=0, running=0, missed=0 throughout; after release with start low, state stays IDLE.
2. Run rate: cfg_div=3, RDY=1, start pulse -> EN high once every 4 cycles, first EN 5 cycles after start; counter stepping 0..15 -> display follows 1,2,...,15,0 with 2-cycle lag; missed stays 0.
3. Backpressure: cfg_div=1, RDY held low for 6 cycles in RUN -> no EN; missed=1 after second tick; RDY high -> exactly one EN next cycle; clr_missed -> missed=0.
4. Single step: IDLE, RDY=0, step pulse -> no EN while RDY low; RDY high -> one EN, state IDLE, display increments by 1; a second step while in STEP is ignored.
5. Priority: start and stop same cycle in IDLE -> stays IDLE, no EN; stop mid-RUN while tick pending -> no further EN, display retains value.
6. cfg_div change: running at cfg_div=100 with prescaler=50, write cfg_div=10 -> tick and EN within 2 cycles, then period 11 cycles; cfg_div=0 -> EN every other cycle.

Source files
------------

// File: rtl/counter_tick_sequencer.sv
// counter_tick_sequencer: paces an external 4-bit counter with one-cycle
// enable pulses. Run, stop and single-step control. The counter value is
// latched for the LEDs. A sticky flag records ticks dropped while a tick
// was still waiting for RDY.
module counter_tick_sequencer #(
  parameter int PRESCALE_W = 21,
  parameter int COUNT_W    = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [PRESCALE_W-1:0] cfg_div,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  step,
  input  logic [COUNT_W-1:0]    count_value,
  input  logic                  RDY_count_value,
  output logic                  EN_count_value,
  output logic [COUNT_W-1:0]    display,
  output logic                  running,
  output logic                  missed,
  input  logic                  clr_missed
);

  typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;

  state_t                state, state_nxt;
  logic [PRESCALE_W-1:0] prescaler;
  logic                  tick_pend;
  logic                  tick;
  logic                  issue;
  logic                  keep_run;
  // vld_pipe[0] is the enable pulse.
  // vld_pipe[1] is the same pulse one cycle later, when the counter has updated.
  logic [1:0]            vld_pipe;

  assign EN_count_value = vld_pipe[0];

  // Next state and enable decision; stop beats start beats step.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (stop)       state_nxt = IDLE;
        else if (start) state_nxt = RUN;
        else if (step)  state_nxt = STEP;
      end
      RUN: begin
        issue = tick_pend && RDY_count_value && !stop && !vld_pipe[0];
        if (stop) state_nxt = IDLE;
      end
      STEP: begin
        if (stop)       state_nxt = IDLE;
        else if (start) state_nxt = RUN;
        else if (RDY_count_value) begin
          issue     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The prescaler only advances while the block stays in RUN across the edge.
  // Entering RUN or leaving it restarts the prescaler from zero.
  assign keep_run = (state == RUN) && (state_nxt == RUN);
  assign tick     = keep_run && (prescaler >= cfg_div);

  // State register; running mirrors the registered state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == RUN);
    end
  end

  // Prescaler with >= wrap, so lowering cfg_div mid-run wraps immediately.
  always_ff @(posedge CLK) begin
    if (RST || !keep_run) prescaler <= '0;
    else if (tick)        prescaler <= '0;
    else                  prescaler <= prescaler + PRESCALE_W'(1);
  end

  // Single-entry tick holder.
  // A tick that arrives while the pending tick is consumed takes its place.
  always_ff @(posedge CLK) begin
    if (RST || !keep_run) tick_pend <= 1'b0;
    else if (issue)       tick_pend <= tick;
    else                  tick_pend <= tick_pend | tick;
  end

  // Enable pulse and its one-cycle-delayed copy used to time the display load.
  always_ff @(posedge CLK) begin
    if (RST) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[0], issue};
  end

  // Display samples the counter on the edge after the counter consumed EN.
  always_ff @(posedge CLK) begin
    if (RST)              display <= '0;
    else if (vld_pipe[1]) display <= count_value;
  end

  // Sticky lost-tick flag; a new loss wins over a simultaneous clear.
  always_ff @(posedge CLK) begin
    if (RST)                              missed <= 1'b0;
    else if (tick && tick_pend && !issue) missed <= 1'b1;
    else if (clr_missed)                  missed <= 1'b0;
  end

endmodule

// File: tb/tb_counter_tick_sequencer.sv
// Bench for counter_tick_sequencer.
// A behavioural 4-bit counter sits on the EN/RDY handshake.
// A rule-level reference model predicts the sequencer outputs.
module tb_counter_tick_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [20:0] cfg_div = '0;
  logic        start = 1'b0, stop = 1'b0, step = 1'b0;
  logic [3:0]  count_value;
  logic        RDY_count_value = 1'b0;
  logic        EN_count_value;
  logic [3:0]  display;
  logic        running, missed;
  logic        clr_missed = 1'b0;

  int checks = 0;
  int failures = 0;

  counter_tick_sequencer #(.PRESCALE_W(21), .COUNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .cfg_div(cfg_div), .start(start), .stop(stop),
    .step(step), .count_value(count_value), .RDY_count_value(RDY_count_value),
    .EN_count_value(EN_count_value), .display(display), .running(running),
    .missed(missed), .clr_missed(clr_missed)
  );

  always #5 CLK = ~CLK;

  // The counter being sequenced: counts on each accepted enable, wraps 15->0.
  logic [3:0] cnt;
  always @(posedge CLK) begin
    if (RST)                 cnt <= 4'd0;
    else if (EN_count_value) cnt <= cnt + 4'd1;
  end
  assign count_value = cnt;

  // Reference model: mode, tick phase, pending tick, pulse history
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2;
  int         m_mode, m_phase;
  bit         m_pend, m_en, m_en_d, m_miss, m_run;
  logic [3:0] m_disp;

  task automatic model_step(input bit r, input bit st, input bit sg, input bit sp,
                            input bit rdy, input bit clr, input int div,
                            input logic [3:0] cv);
    int  nmode;
    bit  fire, tick, stays;
    if (r) begin
      m_mode = M_IDLE; m_phase = 0; m_pend = 0; m_en = 0; m_en_d = 0;
      m_miss = 0; m_run = 0; m_disp = 4'd0;
    end else begin
      // Which mode comes next, from the priority rules.
      if (st)                         nmode = M_IDLE;
      else if (sg && m_mode != M_RUN) nmode = M_RUN;
      else if (sp && m_mode == M_IDLE) nmode = M_STEP;
      else                            nmode = m_mode;
      // Does an enable go out on this edge?
      fire = 0;
      if (m_mode == M_RUN && m_pend && rdy && !st && !m_en) fire = 1;
      if (m_mode == M_STEP && rdy && !st && !sg) begin
        fire = 1;
        nmode = M_IDLE;
      end
      stays = (m_mode == M_RUN) && (nmode == M_RUN);
      tick = stays && (m_phase >= div);
      if (m_en_d) m_disp = cv;
      m_en_d = m_en;
      m_en = fire;
      m_miss = (tick && m_pend && !fire) ? 1'b1 : (m_miss && !clr);
      if (!stays)     m_pend = 0;
      else if (fire)  m_pend = tick;
      else            m_pend = m_pend || tick;
      m_phase = (!stays || tick) ? 0 : m_phase + 1;
      m_mode = nmode;
      m_run = (nmode == M_RUN);
    end
  endtask

  // One clock: snapshot pre-edge inputs, advance the model, settle past the edge.
  task automatic cycle();
    bit r, st, sg, sp, rdy, clr;
    int d;
    logic [3:0] cv;
    r = RST; st = stop; sg = start; sp = step; rdy = RDY_count_value;
    clr = clr_missed; d = int'(cfg_div); cv = count_value;
    @(posedge CLK);
    model_step(r, st, sg, sp, rdy, clr, d, cv);
    #1;
  endtask

  task automatic test_reset();
    RST = 1; start = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if ({EN_count_value, display, running, missed} !== 7'd0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d en=%b disp=%0d run=%b miss=%b want all 0",
                 i, EN_count_value, display, running, missed);
      end
    end
    RST = 0; start = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (running !== 1'b0 || EN_count_value !== 1'b0) begin
        failures++;
        $display("FAIL reset_release cyc=%0d run=%b en=%b want 0 0", i, running, EN_count_value);
      end
    end
  endtask

  task automatic test_run_rate();
    int first, last, changes;
    logic [3:0] prev;
    first = -1; last = -1; changes = 0; prev = display;
    cfg_div = 21'd3; RDY_count_value = 1; start = 1;
    cycle();
    start = 0;
    for (int i = 1; i <= 68; i++) begin
      cycle();
      if (EN_count_value === 1'b1) begin
        if (first < 0) first = i;
        else begin
          checks++;
          if (i - last != 4) begin
            failures++;
            $display("FAIL run_period at=%0d got=%0d want=4", i, i - last);
          end
        end
        last = i;
      end
      if (display !== prev) begin
        changes++;
        checks++;
        if (display !== prev + 4'd1) begin
          failures++;
          $display("FAIL run_display_seq got=%0d want=%0d", display, prev + 4'd1);
        end
        prev = display;
      end
      checks++;
      if (missed !== 1'b0) begin
        failures++;
        $display("FAIL run_missed cyc=%0d got=%b want=0", i, missed);
      end
    end
    checks++;
    if (first != 5) begin
      failures++;
      $display("FAIL run_first_en got=%0d want=5", first);
    end
    checks++;
    if (changes != 16 || display !== 4'd0) begin
      failures++;
      $display("FAIL run_display_count changes=%0d disp=%0d want 16 and 0", changes, display);
    end
    stop = 1; cycle(); stop = 0; cycle(); cycle();
  endtask

  task automatic test_backpressure();
    cfg_div = 21'd1; RDY_count_value = 0; start = 1;
    cycle();
    start = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks++;
      if (EN_count_value !== 1'b0) begin
        failures++;
        $display("FAIL bp_no_en cyc=%0d got=%b want=0", i, EN_count_value);
      end
    end
    checks++;
    if (missed !== 1'b1) begin
      failures++;
      $display("FAIL bp_missed got=%b want=1", missed);
    end
    RDY_count_value = 1;
    cycle();
    checks++;
    if (EN_count_value !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_en got=%b want=1", EN_count_value);
    end
    cycle();
    checks++;
    if (EN_count_value !== 1'b0) begin
      failures++;
      $display("FAIL bp_single_en got=%b want=0", EN_count_value);
    end
    stop = 1; cycle(); stop = 0;
    clr_missed = 1; cycle(); clr_missed = 0;
    checks++;
    if (missed !== 1'b0) begin
      failures++;
      $display("FAIL bp_clr_missed got=%b want=0", missed);
    end
  endtask

  task automatic test_single_step();
    logic [3:0] d0;
    RDY_count_value = 0; cycle(); cycle();
    d0 = display;
    step = 1; cycle(); step = 0;
    for (int i = 0; i < 3; i++) begin
      step = (i == 1);
      cycle();
      checks++;
      if (EN_count_value !== 1'b0 || running !== 1'b0) begin
        failures++;
        $display("FAIL step_wait cyc=%0d en=%b run=%b want 0 0", i, EN_count_value, running);
      end
    end
    step = 0; RDY_count_value = 1;
    cycle();
    checks++;
    if (EN_count_value !== 1'b1) begin
      failures++;
      $display("FAIL step_en got=%b want=1", EN_count_value);
    end
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++;
      if (EN_count_value !== 1'b0 || running !== 1'b0) begin
        failures++;
        $display("FAIL step_once cyc=%0d en=%b run=%b want 0 0", i, EN_count_value, running);
      end
    end
    checks++;
    if (display !== d0 + 4'd1) begin
      failures++;
      $display("FAIL step_display got=%0d want=%0d", display, d0 + 4'd1);
    end
  endtask

  task automatic test_priority();
    logic [3:0] d0;
    start = 1; stop = 1; cycle(); start = 0; stop = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (EN_count_value !== 1'b0 || running !== 1'b0) begin
        failures++;
        $display("FAIL prio_start_stop cyc=%0d en=%b run=%b want 0 0", i, EN_count_value, running);
      end
    end
    cfg_div = 21'd5; RDY_count_value = 0; start = 1;
    cycle(); start = 0;
    repeat (6) cycle();
    d0 = display;
    stop = 1; RDY_count_value = 1; cycle(); stop = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (EN_count_value !== 1'b0 || display !== d0 || running !== 1'b0) begin
        failures++;
        $display("FAIL prio_stop_pending cyc=%0d en=%b disp=%0d run=%b want 0 %0d 0",
                 i, EN_count_value, display, running, d0);
      end
    end
  endtask

  task automatic test_div_change();
    int found, last;
    bit prev_en;
    cfg_div = 21'd100; RDY_count_value = 1; start = 1;
    cycle(); start = 0;
    found = 0;
    repeat (50) begin
      cycle();
      if (EN_count_value === 1'b1) found++;
    end
    checks++;
    if (found != 0) begin
      failures++;
      $display("FAIL div_no_early_en got=%0d want=0", found);
    end
    cfg_div = 21'd10;
    found = -1;
    for (int i = 1; i <= 2; i++) begin
      cycle();
      if (EN_count_value === 1'b1 && found < 0) found = i;
    end
    checks++;
    if (found < 0) begin
      failures++;
      $display("FAIL div_lower_wrap got=none want=EN within 2 cycles");
    end
    last = 0;
    for (int i = 1; i <= 35; i++) begin
      cycle();
      if (EN_count_value === 1'b1) begin
        checks++;
        if (i - last != 11) begin
          failures++;
          $display("FAIL div_period got=%0d want=11", i - last);
        end
        last = i;
      end
    end
    cfg_div = 21'd0;
    repeat (3) cycle();
    prev_en = EN_count_value;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (EN_count_value === prev_en) begin
        failures++;
        $display("FAIL div_zero_alt cyc=%0d got=%b want=%b", i, EN_count_value, !prev_en);
      end
      prev_en = EN_count_value;
    end
    stop = 1; cycle(); stop = 0; cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      RST = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 19) == 0);
      stop = ($urandom_range(0, 24) == 0);
      step = ($urandom_range(0, 14) == 0);
      RDY_count_value = ($urandom_range(0, 3) != 0);
      clr_missed = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 29) == 0) cfg_div = 21'($urandom_range(0, 6));
      cycle();
      checks++;
      if (EN_count_value !== m_en || display !== m_disp ||
          running !== m_run || missed !== m_miss) begin
        failures++;
        $display("FAIL rand cyc=%0d en/disp/run/miss got=%b/%0d/%b/%b want=%b/%0d/%b/%b",
                 i, EN_count_value, display, running, missed, m_en, m_disp, m_run, m_miss);
      end
    end
    RST = 0; start = 0; stop = 0; step = 0; clr_missed = 0;
  endtask

  initial begin
    test_reset();
    test_run_rate();
    test_backpressure();
    test_single_step();
    test_priority();
    test_div_change();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
